// File: rtl/ah_pkt_dispatch_pkg.sv
// Shared types and constants for the packet dispatcher: FSM states, error codes,
// one-hot classification and counter width.
package ah_dispatch_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_ERR = 2'd2} state_t;
  typedef enum logic [1:0] {OH_ZERO = 2'd0, OH_ONE = 2'd1, OH_MULTI = 2'd2} oh_cls_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MISS  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/ah_pkt_dispatch_if.sv
// Ingress, decoder, egress and error-reporting signals of the dispatcher.
interface ah_pkt_dispatch_if import ah_dispatch_pkg::*; #(
  parameter int NUM_CLIENTS = 20,
  parameter int FIELD_W     = 10,
  parameter int DATA_W      = 32
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [FIELD_W-1:0]     in_field;
  logic [DATA_W-1:0]      in_data;
  logic [NUM_CLIENTS-1:0] dec_onehot;
  logic                   dec_err;
  logic [NUM_CLIENTS-1:0] out_valid;
  logic [NUM_CLIENTS-1:0] out_ready;
  logic [FIELD_W-1:0]     out_field;
  logic [DATA_W-1:0]      out_data;
  logic                   err_pulse;
  logic [1:0]             err_code;
  logic [CNT_W-1:0]       err_count;

  modport master (
    output in_valid, in_field, in_data, dec_onehot, dec_err, out_ready,
    input  in_ready, out_valid, out_field, out_data, err_pulse, err_code, err_count
  );
  modport slave (
    input  in_valid, in_field, in_data, dec_onehot, dec_err, out_ready,
    output in_ready, out_valid, out_field, out_data, err_pulse, err_code, err_count
  );
endinterface

// File: rtl/ah_onehot_chk.sv
// Combinational classifier of a select vector: no bit, exactly one bit, or several bits set.
module ah_onehot_chk import ah_dispatch_pkg::*; #(
  parameter int N = 20
) (
  input  logic [N-1:0] i_vec,
  output oh_cls_t      o_cls
);
  logic w_any, w_multi;

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign w_any   = |i_vec;
  assign w_multi = |(i_vec & (i_vec - N'(1)));

  always_comb begin
    o_cls = OH_ZERO;
    if (w_multi)    o_cls = OH_MULTI;
    else if (w_any) o_cls = OH_ONE;
  end
endmodule

// File: rtl/ah_pkt_dispatch.sv
// Single-packet dispatcher: captures a decoded packet, presents it to one client
// until handshake or timeout, and reports miss/multi-hit/timeout errors.
module ah_pkt_dispatch import ah_dispatch_pkg::*; #(
  parameter int NUM_CLIENTS = 20,
  parameter int FIELD_W     = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input logic              clk,
  input logic              rst,
  ah_pkt_dispatch_if.slave bus
);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 r_state;
  logic                   r_live;
  logic [NUM_CLIENTS-1:0] r_onehot;
  logic [FIELD_W-1:0]     r_field;
  logic [DATA_W-1:0]      r_data;
  logic [CNT_W-1:0]       r_wait;
  logic [1:0]             r_code;
  logic [CNT_W-1:0]       r_cnt;

  oh_cls_t w_cls;
  logic    w_ready, w_accept, w_hs, w_tmo;

  ah_onehot_chk #(.N(NUM_CLIENTS)) u_chk (
    .i_vec (bus.dec_onehot),
    .o_cls (w_cls)
  );

  // r_live keeps in_ready low until the first edge after reset release.
  assign w_ready  = r_live && (r_state == ST_IDLE);
  assign w_accept = bus.in_valid && w_ready;
  assign w_hs     = (r_state == ST_HOLD) && |(r_onehot & bus.out_ready);
  assign w_tmo    = (r_wait == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_live   <= 1'b0;
      r_onehot <= '0;
      r_field  <= '0;
      r_data   <= '0;
      r_wait   <= '0;
      r_code   <= ERR_NONE;
      r_cnt    <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_field  <= bus.in_field;
          r_data   <= bus.in_data;
          r_onehot <= bus.dec_onehot;
          r_wait   <= '0;
          // Multi-hit outranks the decoder's own miss flag.
          case (w_cls)
            OH_MULTI: begin r_state <= ST_ERR; r_code <= ERR_MULTI; end
            OH_ONE: begin
              if (bus.dec_err) begin r_state <= ST_ERR; r_code <= ERR_MISS; end
              else r_state <= ST_HOLD;
            end
            default: begin r_state <= ST_ERR; r_code <= ERR_MISS; end
          endcase
        end
        ST_HOLD: begin
          if (w_hs)       r_state <= ST_IDLE;
          else if (w_tmo) begin r_state <= ST_ERR; r_code <= ERR_TMO; end
          else            r_wait <= r_wait + 1'b1;
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = (r_state == ST_HOLD) ? r_onehot : '0;
  assign bus.out_field = r_field;
  assign bus.out_data  = r_data;
  assign bus.err_pulse = (r_state == ST_ERR);
  assign bus.err_code  = (r_state == ST_ERR) ? r_code : ERR_NONE;
  assign bus.err_count = r_cnt;
endmodule

// File: tb/tb_ah_pkt_dispatch.sv
// Bench for ah_pkt_dispatch: a default-timeout instance and a TIMEOUT=4 instance,
// table vectors plus random packets checked against a transaction-level model.
module tb_ah_pkt_dispatch;
  localparam int NC = 20;
  localparam int FW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic          s_in_valid = 1'b0;
  logic [FW-1:0] s_field    = '0;
  logic [DW-1:0] s_data     = '0;
  logic [NC-1:0] s_oh       = '0;
  logic          s_derr     = 1'b0;
  logic [NC-1:0] s_ready    = '0;

  ah_pkt_dispatch_if #(.NUM_CLIENTS(NC), .FIELD_W(FW), .DATA_W(DW)) bus ();
  ah_pkt_dispatch_if #(.NUM_CLIENTS(NC), .FIELD_W(FW), .DATA_W(DW)) bt ();

  ah_pkt_dispatch #(.NUM_CLIENTS(NC), .FIELD_W(FW), .DATA_W(DW), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  ah_pkt_dispatch #(.NUM_CLIENTS(NC), .FIELD_W(FW), .DATA_W(DW), .TIMEOUT(4)) u_tmo (
    .clk(clk), .rst(rst), .bus(bt));

  assign bus.in_valid   = s_in_valid & ~sel;
  assign bt.in_valid    = s_in_valid & sel;
  assign bus.in_field   = s_field;
  assign bt.in_field    = s_field;
  assign bus.in_data    = s_data;
  assign bt.in_data     = s_data;
  assign bus.dec_onehot = s_oh;
  assign bt.dec_onehot  = s_oh;
  assign bus.dec_err    = s_derr;
  assign bt.dec_err     = s_derr;
  assign bus.out_ready  = sel ? '0 : s_ready;
  assign bt.out_ready   = sel ? s_ready : '0;

  logic          o_ready, o_pulse;
  logic [NC-1:0] o_valid;
  logic [FW-1:0] o_field;
  logic [DW-1:0] o_data;
  logic [1:0]    o_code;
  logic [7:0]    o_count;
  assign o_ready = sel ? bt.in_ready  : bus.in_ready;
  assign o_pulse = sel ? bt.err_pulse : bus.err_pulse;
  assign o_valid = sel ? bt.out_valid : bus.out_valid;
  assign o_field = sel ? bt.out_field : bus.out_field;
  assign o_data  = sel ? bt.out_data  : bus.out_data;
  assign o_code  = sel ? bt.err_code  : bus.err_code;
  assign o_count = sel ? bt.err_count : bus.err_count;

  int total = 0;
  int bad   = 0;
  int ecnt[2] = '{0, 0};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Outcome of one packet from the rules: classification, then ready delay vs timeout.
  function automatic void model(input logic s, input logic [NC-1:0] oh, input logic de,
                                input int dly, output logic [1:0] code, output int hold);
    int t    = s ? 4 : 255;
    int ones = $countones(oh);
    hold = 0;
    if (ones >= 2)              code = 2'b10;
    else if (de || ones == 0)   code = 2'b01;
    else if (dly >= t) begin    code = 2'b11; hold = t; end
    else begin                  code = 2'b00; hold = dly + 1; end
  endfunction

  task automatic run_pkt(input logic s, input logic [FW-1:0] f, input logic [DW-1:0] d,
                         input logic [NC-1:0] oh, input logic de, input int dly,
                         input logic [NC-1:0] noise, input logic [1:0] ecode, input int ehold);
    int n = 0;
    sel = s;
    #1;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_idle", {63'd0, o_ready}, 64'd1);
    s_in_valid = 1'b1; s_field = f; s_data = d; s_oh = oh; s_derr = de;
    s_ready = noise & ~oh;
    @(negedge clk);
    s_in_valid = 1'b0; s_field = ~f; s_data = ~d; s_oh = '0; s_derr = 1'b0;
    chk("in_ready_busy", {63'd0, o_ready}, 64'd0);
    if (ecode == 2'b01 || ecode == 2'b10) begin
      chk("err_pulse", {63'd0, o_pulse}, 64'd1);
      chk("err_code", {62'd0, o_code}, {62'd0, ecode});
      chk("out_valid_err", {44'd0, o_valid}, 64'd0);
    end else begin
      for (int i = 0; i < ehold; i++) begin
        chk("out_valid", {44'd0, o_valid}, {44'd0, oh});
        chk("out_field", {54'd0, o_field}, {54'd0, f});
        chk("out_data", {32'd0, o_data}, {32'd0, d});
        chk("no_pulse_hold", {63'd0, o_pulse}, 64'd0);
        s_ready = ((i >= dly) ? oh : '0) | (noise & ~oh);
        @(negedge clk);
      end
      s_ready = '0;
      chk("out_valid_end", {44'd0, o_valid}, 64'd0);
      chk("err_pulse_end", {63'd0, o_pulse}, {63'd0, ecode == 2'b11});
      chk("err_code_end", {62'd0, o_code}, {62'd0, ecode});
    end
    if (ecode != 2'b00) begin
      ecnt[s] = (ecnt[s] < 255) ? ecnt[s] + 1 : 255;
      @(negedge clk);
      chk("pulse_one_cycle", {63'd0, o_pulse}, 64'd0);
      chk("code_idle", {62'd0, o_code}, 64'd0);
    end
    chk("in_ready_after", {63'd0, o_ready}, 64'd1);
    chk("err_count", {56'd0, o_count}, ecnt[s]);
  endtask

  typedef struct {
    logic          s;
    logic [FW-1:0] f;
    logic [DW-1:0] d;
    logic [NC-1:0] oh;
    logic          de;
    int            dly;
    logic [1:0]    ecode;
    int            ehold;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [NC-1:0] oh, noise;
    logic [1:0]    code;
    int            hold, dly, k1, k2;
    logic          s, de;

    tbl[0] = '{1'b0, 10'h005, 32'hDEAD_0005, 20'h00008, 1'b0, 0,  2'b00, 1};
    tbl[1] = '{1'b0, 10'h1A3, 32'hCAFE_F00D, 20'h80000, 1'b0, 10, 2'b00, 11};
    tbl[2] = '{1'b0, 10'h0F0, 32'h1111_2222, 20'h00008, 1'b1, 0,  2'b01, 0};
    tbl[3] = '{1'b0, 10'h0F1, 32'h3333_4444, 20'h00011, 1'b0, 0,  2'b10, 0};
    tbl[4] = '{1'b0, 10'h3FF, 32'h5555_6666, 20'h00000, 1'b0, 0,  2'b01, 0};
    tbl[5] = '{1'b0, 10'h200, 32'h7777_8888, 20'h00011, 1'b1, 0,  2'b10, 0};
    tbl[6] = '{1'b1, 10'h011, 32'hA5A5_A5A5, 20'h00100, 1'b0, 9,  2'b11, 4};
    tbl[7] = '{1'b1, 10'h022, 32'h5A5A_5A5A, 20'h00100, 1'b0, 3,  2'b00, 4};
    tbl[8] = '{1'b1, 10'h033, 32'h0BAD_F00D, 20'h00001, 1'b0, 4,  2'b11, 4};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, o_ready}, 64'd0);
    chk("rst_out_valid", {44'd0, o_valid}, 64'd0);
    chk("rst_err_pulse", {63'd0, o_pulse}, 64'd0);
    chk("rst_err_code", {62'd0, o_code}, 64'd0);
    chk("rst_err_count", {56'd0, o_count}, 64'd0);
    chk("rst_out_field", {54'd0, o_field}, 64'd0);
    chk("rst_out_data", {32'd0, o_data}, 64'd0);
    #2 rst = 1'b0;
    chk("in_ready_before_edge", {63'd0, o_ready}, 64'd0);
    @(negedge clk);
    chk("in_ready_after_edge", {63'd0, o_ready}, 64'd1);

    for (int i = 0; i < 9; i++)
      run_pkt(tbl[i].s, tbl[i].f, tbl[i].d, tbl[i].oh, tbl[i].de, tbl[i].dly,
              20'h5A5A5, tbl[i].ecode, tbl[i].ehold);

    for (int i = 0; i < 150; i++) begin
      s = 1'(($urandom % 2));
      de = ($urandom_range(0, 3) == 0);
      oh = '0;
      case ($urandom_range(0, 5))
        0, 1, 2: oh[$urandom_range(0, NC-1)] = 1'b1;
        3: oh = '0;
        4: begin
          k1 = $urandom_range(0, NC-1);
          k2 = (k1 + $urandom_range(1, NC-1)) % NC;
          oh[k1] = 1'b1; oh[k2] = 1'b1;
        end
        default: oh = NC'($urandom);
      endcase
      dly = s ? $urandom_range(0, 6) : $urandom_range(0, 20);
      noise = NC'($urandom);
      model(s, oh, de, dly, code, hold);
      run_pkt(s, FW'($urandom), $urandom, oh, de, dly, noise, code, hold);
    end

    // Error counter saturation on the main instance
    for (int i = 0; i < 300; i++)
      run_pkt(1'b0, FW'(i), 32'(i), '0, 1'b1, 0, '0, 2'b01, 0);
    chk("err_count_sat", {56'd0, o_count}, 64'd255);

    // Reset in the middle of HOLD drops the packet silently
    sel = 1'b0;
    #1;
    s_in_valid = 1'b1; s_field = 10'h155; s_data = 32'h1234_5678; s_oh = 20'h00040;
    s_derr = 1'b0; s_ready = '0;
    @(negedge clk);
    s_in_valid = 1'b0; s_oh = '0;
    chk("hold_before_rst", {44'd0, o_valid}, 64'h40);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_hold_out_valid", {44'd0, o_valid}, 64'd0);
    chk("rst_hold_err_pulse", {63'd0, o_pulse}, 64'd0);
    chk("rst_hold_err_count", {56'd0, o_count}, 64'd0);
    chk("rst_hold_in_ready", {63'd0, o_ready}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    ecnt[0] = 0; ecnt[1] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_pulse", {63'd0, o_pulse}, 64'd0);
      chk("post_rst_count", {56'd0, o_count}, 64'd0);
    end
    run_pkt(1'b0, 10'h005, 32'hFEED_BEEF, 20'h00008, 1'b0, 2, 20'h00000, 2'b00, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ah_pkt_dispatch.md
AH_PKT_DISPATCH -- requirements
Module: ah_pkt_dispatch

Interface
REQ-001 Parameter NUM_CLIENTS, default 20: number of client egress ports; width of the decoder one-hot input.
REQ-002 Parameter FIELD_W, default 10: width of the packet decode field.
REQ-003 Parameter DATA_W, default 32: width of the packet payload.
REQ-004 Parameter TIMEOUT, default 255: maximum HOLD cycles before the packet is dropped; legal range 1..255.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  ingress packet valid.
REQ-009 in_ready  out  1  ingress packet accepted when in_valid && in_ready.
REQ-010 in_field  in  FIELD_W  packet decode field, also driven to the upstream decoder.
REQ-011 in_data  in  DATA_W  packet payload.
REQ-012 dec_onehot  in  NUM_CLIENTS  decoder result for in_field, same cycle.
REQ-013 dec_err  in  1  decoder miss flag, same cycle.
REQ-014 out_valid  out  NUM_CLIENTS  per-client valid; at most one bit set.
REQ-015 out_ready  in  NUM_CLIENTS  per-client ready.
REQ-016 out_field  out  FIELD_W  captured field, common to all clients.
REQ-017 out_data  out  DATA_W  captured payload, common to all clients.
REQ-018 err_pulse  out  1  one-cycle error strobe.
REQ-019 err_code  out  2  error cause, valid with err_pulse: 01 miss, 10 multi-hit, 11 timeout.
REQ-020 err_count  out  8  saturating count of error events.

Function
REQ-021 The FSM SHALL have three states: IDLE, HOLD and ERR.
REQ-022 in_ready SHALL be 1 only in IDLE.
REQ-023 On acceptance, the block SHALL register in_field, in_data and dec_onehot into capture registers.
REQ-024 From IDLE, an accepted packet with exactly one dec_onehot bit set and dec_err=0 SHALL transition to HOLD.
REQ-025 From IDLE, an accepted packet with dec_err=1 or dec_onehot all zero SHALL transition to ERR with code 01.
REQ-026 From IDLE, an accepted packet with two or more dec_onehot bits set SHALL transition to ERR with code 10; multi-hit takes priority over dec_err.
REQ-027 In HOLD, out_valid SHALL equal the captured one-hot, and out_valid, out_field and out_data SHALL remain stable until the handshake.
REQ-028 In HOLD, when out_ready[k] is 1 for the captured client k, the transfer SHALL complete in that cycle and the FSM SHALL return to IDLE; out_ready bits for other clients are ignored.
REQ-029 On entry to HOLD, the wait counter SHALL load 0 and increment each HOLD cycle without handshake.
REQ-030 When the wait counter reaches TIMEOUT-1 without a handshake, the packet SHALL be dropped: out_valid clears the next cycle and the FSM enters ERR with code 11.
REQ-031 If the handshake and the timeout occur in the same cycle, the handshake SHALL win and no error is raised.
REQ-032 ERR SHALL last exactly one cycle, with err_pulse=1 and err_code set, then return to IDLE.
REQ-033 err_code SHALL be 00 whenever err_pulse=0.
REQ-034 err_count SHALL increment on each err_pulse and saturate at 255.
REQ-035 Latency SHALL be: accept at edge N gives out_valid or err_pulse high in cycle N+1.
REQ-036 Minimum spacing between accepts SHALL be 2 cycles.

Reset
REQ-037 While rst=1, the FSM SHALL be in IDLE.
REQ-038 While rst=1, in_ready SHALL be 0; it goes to 1 on the first clk edge after rst deasserts.
REQ-039 While rst=1, out_valid=0, err_pulse=0, err_code=00 and err_count=0.
REQ-040 While rst=1, the wait counter and capture registers SHALL be 0.
REQ-041 Reset asserted during HOLD SHALL drop the packet silently, with no err_pulse and no err_count change.

Structure
REQ-042 Package ah_dispatch_pkg SHALL hold the FSM state enum, the err_code constants (ERR_NONE, ERR_MISS, ERR_MULTI, ERR_TMO) and the counter width.
REQ-043 Sub-module ah_onehot_chk SHALL classify a NUM_CLIENTS vector as zero, one or multi, combinationally.
REQ-044 The decoder SHALL NOT be instantiated inside this block; dec_onehot and dec_err arrive as ports.

Verification
REQ-045 Single hit: in_field=0x005, dec_onehot bit 3, out_ready[3]=1 -> out_valid=0x00008 one cycle after accept, then IDLE; in_ready high one cycle later.
REQ-046 Backpressure: dec_onehot bit 19, out_ready[19] held 0 for 10 cycles then 1 -> out_valid=0x80000 stable for 11 cycles with out_data unchanged; no error.
REQ-047 Miss and multi-hit: dec_err=1 -> err_pulse with code 01; dec_onehot=0x00011 -> err_pulse with code 10; err_count=2.
REQ-048 Timeout: TIMEOUT=4, out_ready=0 -> out_valid high 4 cycles, then err_pulse with code 11; handshake in the final HOLD cycle -> no error.
REQ-049 Saturation and reset: 300 consecutive misses -> err_count=255; rst pulsed mid-HOLD -> out_valid=0 immediately, err_count=0, no err_pulse.
